// File: rtl/lane_deskew_merge.sv
// rtl/lane_deskew_merge.sv - two-lane alignment, skew absorption and 16-bit in-order re-merge
module lane_deskew_merge #(
    parameter logic [7:0] ALIGN_SYM  = 8'hBC,
    parameter int         MAX_SKEW   = 4,
    parameter int         FIFO_DEPTH = 6
) (
    input  logic        fsm_clk,
    input  logic        rst,
    input  logic        rx_lanes_on,
    input  logic [7:0]  lane_0_rx,
    input  logic        lane_0_vld,
    input  logic [7:0]  lane_1_rx,
    input  logic        lane_1_vld,
    output logic [15:0] data_out,
    output logic        data_vld,
    output logic        aligned,
    output logic        deskew_err,
    output logic [2:0]  skew,
    output logic        skew_lead
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [2:0]    MAX_L   = 3'(MAX_SKEW);
    localparam logic [2:0]    LIMIT_L = 3'(MAX_SKEW + 1);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HUNT, WAIT_LAG, ALIGNED} state_t;

    state_t          state, state_nxt;
    logic [7:0]      rx      [2];
    logic [1:0]      vld;
    logic [1:0]      mark;
    logic [1:0]      push;
    logic [1:0]      full;
    logic            pop;
    logic            ovf;
    logic            other_mark;
    logic            flush;
    logic            err;
    logic [2:0]      lag_cnt;
    logic [2:0]      lag_now;
    logic [7:0]      mem     [2][FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr  [2];
    logic [PW-1:0]   rd_ptr  [2];
    logic [CW-1:0]   cnt     [2];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    assign rx[0]   = lane_0_rx;
    assign rx[1]   = lane_1_rx;
    assign vld     = {lane_1_vld, lane_0_vld};
    assign mark[0] = lane_0_vld && (lane_0_rx == ALIGN_SYM);
    assign mark[1] = lane_1_vld && (lane_1_rx == ALIGN_SYM);
    assign full[0] = (cnt[0] == FULL_C);
    assign full[1] = (cnt[1] == FULL_C);
    assign lag_now = lag_cnt + 3'd1;
    assign other_mark = skew_lead ? mark[0] : mark[1];
    assign aligned = (state == ALIGNED);

    // Only the lane that locked first buffers while the other lane is still hunting.
    always_comb begin
        push = 2'b00;
        if (state == ALIGNED)
            push = vld;
        else if (state == WAIT_LAG)
            push = skew_lead ? {vld[1], 1'b0} : {1'b0, vld[0]};
    end

    assign pop = (state == ALIGNED) && (cnt[0] != '0) && (cnt[1] != '0);
    assign ovf = |(push & full & {2{~pop}});

    always_comb begin
        state_nxt = state;
        flush     = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE:     state_nxt = HUNT;
            HUNT: begin
                if (mark[0] && mark[1])
                    state_nxt = ALIGNED;
                else if (mark[0] || mark[1])
                    state_nxt = WAIT_LAG;
            end
            WAIT_LAG: begin
                if (ovf) begin
                    err = 1'b1; flush = 1'b1; state_nxt = HUNT;
                end else if (other_mark && (lag_now <= MAX_L)) begin
                    state_nxt = ALIGNED;
                end else if (lag_now >= LIMIT_L) begin
                    err = 1'b1; flush = 1'b1; state_nxt = HUNT;
                end
            end
            ALIGNED: begin
                if (ovf) begin
                    err = 1'b1; flush = 1'b1; state_nxt = HUNT;
                end
            end
            default:  state_nxt = IDLE;
        endcase
        if (!rx_lanes_on) begin
            state_nxt = IDLE;
            flush     = 1'b1;
            err       = 1'b0;
        end
    end

    always_ff @(posedge fsm_clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i] && !flush)
                mem[i][wr_ptr[i]] <= rx[i];
    end

    always_ff @(posedge fsm_clk) begin
        if (rst) begin
            state      <= IDLE;
            data_out   <= '0;
            data_vld   <= 1'b0;
            deskew_err <= 1'b0;
            skew       <= '0;
            skew_lead  <= 1'b0;
            lag_cnt    <= '0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            state      <= state_nxt;
            deskew_err <= err;
            data_vld   <= 1'b0;
            if (flush) begin
                skew      <= '0;
                skew_lead <= 1'b0;
                for (int i = 0; i < 2; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    cnt[i]    <= '0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                    if (pop)     rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                    cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop);
                end
                if (pop) begin
                    data_out <= {mem[1][rd_ptr[1]], mem[0][rd_ptr[0]]};
                    data_vld <= 1'b1;
                end
                if (state == HUNT) begin
                    lag_cnt <= '0;
                    if (mark[0] && mark[1]) begin
                        skew      <= '0;
                        skew_lead <= 1'b0;
                    end else if (mark[0] || mark[1]) begin
                        skew_lead <= mark[1];
                    end
                end else if (state == WAIT_LAG) begin
                    lag_cnt <= lag_now;
                    if (state_nxt == ALIGNED)
                        skew <= lag_now;
                end
            end
        end
    end
endmodule
